// File: rtl/tdc_hit_encoder_pkg.sv
// Shared defaults, width helper and timestamp layout for the TDC hit encoder.
// The timestamp packs {coarse, fine} with the fine code in the LSBs.
package tdc_hit_encoder_pkg;

    localparam int DEF_N_TAPS     = 12;
    localparam int DEF_COARSE_W   = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    // Elaboration-time ceil(log2(value)); the bounded loop keeps it synthesizable.
    function automatic int f_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEF_FINE_W = f_clog2(DEF_N_TAPS + 1);
    localparam int FINE_LSB   = 0;
    localparam int COARSE_LSB = DEF_FINE_W;

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
    } ts_t;

endpackage

// File: rtl/tdc_hit_encoder_if.sv
// Timestamp readout bus: FWFT head data with a valid/ready handshake.
interface tdc_hit_encoder_if #(
    parameter int WIDTH = 20
) ();

    logic [WIDTH-1:0] ts_data;
    logic             ts_valid;
    logic             ts_ready;

    modport master (
        output ts_data,
        output ts_valid,
        input  ts_ready
    );

    modport slave (
        input  ts_data,
        input  ts_valid,
        output ts_ready
    );

endinterface

// File: rtl/tdc_ts_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// When empty, rd_data keeps showing the most recently popped word.
module tdc_ts_fifo
    import tdc_hit_encoder_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = f_clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_last;

    logic             w_do_rd;
    logic             w_do_wr;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);

    // A pop frees the head slot in the same edge, so a full FIFO can still accept a write.
    assign w_do_rd  = rd_en && !empty;
    assign w_do_wr  = wr_en && (!full || w_do_rd);

    assign rd_data  = empty ? r_last : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[w_wr_idx] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_last   <= r_mem[w_rd_idx];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_hit_encoder.sv
// Bubble-corrects and encodes the latched delay-line taps, detects hit rising
// edges and queues {coarse, fine} timestamps for readout.
module tdc_hit_encoder
    import tdc_hit_encoder_pkg::*;
#(
    parameter int N_TAPS     = DEF_N_TAPS,
    parameter int COARSE_W   = DEF_COARSE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_TAPS-1:0] taps,
    tdc_hit_encoder_if.master ts,
    output logic              overflow
);

    localparam int FINE_W         = f_clog2(N_TAPS + 1);
    localparam int TS_W           = COARSE_W + FINE_W;
    localparam int COARSE_LSB_LOC = FINE_LSB + FINE_W;

    logic [N_TAPS-1:0]   r_taps_q;
    logic [N_TAPS-1:0]   r_taps_q2;
    logic [1:0]          r_live;
    logic                r_prev_tap0;
    logic [COARSE_W-1:0] r_cnt;
    logic                r_overflow;

    logic [N_TAPS+1:0]   w_ext;
    logic [N_TAPS-1:0]   w_corr;
    logic [FINE_W-1:0]   w_fine;
    logic                w_ev;
    logic [TS_W-1:0]     w_wr_data;
    logic                w_full;
    logic                w_empty;

    // Majority of each tap with its neighbours; the end taps are replicated outward.
    always_comb begin
        w_ext  = {r_taps_q2[N_TAPS-1], r_taps_q2, r_taps_q2[0]};
        w_corr = '0;
        w_fine = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            w_corr[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) | (w_ext[i+1] & w_ext[i+2]);
            w_fine    = w_fine + FINE_W'(w_corr[i]);
        end
    end

    assign w_ev = r_taps_q2[0] && !r_prev_tap0;

    always_comb begin
        w_wr_data = '0;
        w_wr_data[FINE_LSB +: FINE_W]         = w_fine;
        w_wr_data[COARSE_LSB_LOC +: COARSE_W] = r_cnt;
    end

    // r_live tracks which pipeline stages hold real samples rather than reset zeros,
    // so a hit held high through reset cannot look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps_q    <= '0;
            r_taps_q2   <= '0;
            r_live      <= 2'b00;
            r_prev_tap0 <= 1'b1;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_taps_q    <= taps;
            r_taps_q2   <= r_taps_q;
            r_live      <= {r_live[0], 1'b1};
            r_prev_tap0 <= r_taps_q2[0] | ~r_live[1];
            r_cnt       <= r_cnt + 1'b1;
            if (w_ev && w_full && !ts.ts_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    tdc_ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_ev),
        .wr_data (w_wr_data),
        .full    (w_full),
        .rd_en   (ts.ts_ready),
        .rd_data (ts.ts_data),
        .empty   (w_empty)
    );

    assign ts.ts_valid = !w_empty;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Directed, table-driven bench for tdc_hit_encoder with hand-computed timestamps.
module tb_tdc_hit_encoder;
    import tdc_hit_encoder_pkg::*;

    localparam logic [11:0] ALL_ONES = 12'hFFF;

    typedef struct {
        int          idle;
        logic [11:0] taps;
        logic [15:0] coarse;
        logic [3:0]  fine;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [11:0] taps;
    logic        overflow;

    int          checks;
    int          errors;
    int          validCycles;
    int          tbCnt;
    logic [19:0] tsQ[$];
    vec_t        vecs[7];

    tdc_hit_encoder_if #(.WIDTH(20)) tsIf ();

    tdc_hit_encoder #(
        .N_TAPS     (12),
        .COARSE_W   (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .taps     (taps),
        .ts       (tsIf.master),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted head word and how many cycles the head was valid.
    always @(negedge clk) begin
        if (tsIf.ts_valid && tsIf.ts_ready) begin
            tsQ.push_back(tsIf.ts_data);
        end
        if (tsIf.ts_valid) begin
            validCycles++;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        tbCnt++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expectTs(input string name, input logic [15:0] coarse, input logic [3:0] fine);
        ts_t t;
        if (tsQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no timestamp, expected coarse %0d fine %0d", name, coarse, fine);
        end else begin
            t = tsQ.pop_front();
            checkOutput({name, "_coarse"}, 32'(t.coarse), 32'(coarse));
            checkOutput({name, "_fine"}, 32'(t.fine), 32'(fine));
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tbCnt = 0;
        tsQ.delete();
        validCycles = 0;
    endtask

    task automatic idle(input int n);
        taps = 12'h000;
        repeat (n) step();
    endtask

    // Reset, idle, one sampled pattern, then all-ones held so no second edge appears.
    task automatic applyStimulus(input int idx, input vec_t v);
        string name;
        name = $sformatf("vec%0d", idx);
        tsIf.ts_ready = 1'b1;
        doReset();
        idle(v.idle);
        taps = v.taps;
        step();
        taps = ALL_ONES;
        repeat (6) step();
        checkOutput({name, "_count"}, 32'(tsQ.size()), 32'd1);
        checkOutput({name, "_validCycles"}, 32'(validCycles), 32'd1);
        expectTs(name, v.coarse, v.fine);
    endtask

    task automatic queueEvents(input int n);
        logic [11:0] pat;
        for (int k = 0; k < n; k++) begin
            pat = 12'((13'd1 << (k + 1)) - 13'd1);
            taps = pat;
            step();
            taps = 12'h000;
            step();
            step();
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        validCycles = 0;
        tbCnt       = 0;
        rst         = 1'b1;
        taps        = 12'h000;
        tsIf.ts_ready = 1'b0;

        vecs[0] = '{idle: 5, taps: 12'b000000011111, coarse: 16'd7,  fine: 4'd5};
        vecs[1] = '{idle: 5, taps: 12'b000001011111, coarse: 16'd7,  fine: 4'd6};
        vecs[2] = '{idle: 9, taps: 12'b111111111111, coarse: 16'd11, fine: 4'd12};
        vecs[3] = '{idle: 3, taps: 12'b000000000001, coarse: 16'd5,  fine: 4'd1};
        vecs[4] = '{idle: 7, taps: 12'b000000011101, coarse: 16'd9,  fine: 4'd5};
        vecs[5] = '{idle: 4, taps: 12'b011111111111, coarse: 16'd6,  fine: 4'd11};
        vecs[6] = '{idle: 6, taps: 12'b000010111111, coarse: 16'd8,  fine: 4'd7};

        // Reset state and quiet taps.
        doReset();
        checkOutput("rst_valid", 32'(tsIf.ts_valid), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_data", 32'(tsIf.ts_data), 32'd0);
        tsIf.ts_ready = 1'b1;
        idle(10);
        checkOutput("quiet_writes", 32'(tsQ.size()), 32'd0);
        checkOutput("quiet_validCycles", 32'(validCycles), 32'd0);
        checkOutput("quiet_overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Hit held high must not re-trigger until tap 0 drops.
        tsIf.ts_ready = 1'b1;
        doReset();
        idle(5);
        taps = ALL_ONES;
        repeat (30) step();
        taps = 12'h000;
        repeat (3) step();
        taps = ALL_ONES;
        repeat (6) step();
        checkOutput("rearm_count", 32'(tsQ.size()), 32'd2);
        expectTs("rearm_first", 16'd7, 4'd12);
        expectTs("rearm_second", 16'd40, 4'd12);

        // Five events into a stalled FIFO: four kept, fifth dropped.
        tsIf.ts_ready = 1'b0;
        doReset();
        idle(5);
        queueEvents(5);
        repeat (4) step();
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_valid", 32'(tsIf.ts_valid), 32'd1);
        checkOutput("ovf_head", 32'(tsIf.ts_data), 32'({16'd7, 4'd1}));
        tsIf.ts_ready = 1'b1;
        repeat (6) step();
        checkOutput("ovf_drain_count", 32'(tsQ.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            expectTs($sformatf("ovf_entry%0d", k), 16'(7 + 3 * k), 4'(k + 1));
        end
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        checkOutput("ovf_empty", 32'(tsIf.ts_valid), 32'd0);

        // Full FIFO with write and pop on the same edge.
        tsIf.ts_ready = 1'b0;
        doReset();
        idle(5);
        queueEvents(4);
        taps = 12'b000000011111;
        step();
        taps = 12'h000;
        step();
        tsIf.ts_ready = 1'b1;
        step();
        tsIf.ts_ready = 1'b0;
        checkOutput("simul_overflow", 32'(overflow), 32'd0);
        checkOutput("simul_valid", 32'(tsIf.ts_valid), 32'd1);
        tsIf.ts_ready = 1'b1;
        repeat (6) step();
        checkOutput("simul_count", 32'(tsQ.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            expectTs($sformatf("simul_entry%0d", k), 16'(7 + 3 * k), 4'(k + 1));
        end
        checkOutput("simul_overflow_end", 32'(overflow), 32'd0);

        // Reset with two entries queued and the hit held high.
        tsIf.ts_ready = 1'b0;
        doReset();
        idle(5);
        taps = ALL_ONES;
        step();
        taps = 12'h000;
        step();
        step();
        taps = ALL_ONES;
        repeat (4) step();
        checkOutput("midrst_pre_valid", 32'(tsIf.ts_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        tbCnt = 0;
        tsQ.delete();
        validCycles = 0;
        checkOutput("midrst_valid", 32'(tsIf.ts_valid), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_data", 32'(tsIf.ts_data), 32'd0);
        tsIf.ts_ready = 1'b1;
        repeat (10) step();
        checkOutput("midrst_no_event", 32'(tsQ.size()), 32'd0);
        checkOutput("midrst_validCycles", 32'(validCycles), 32'd0);
        taps = 12'h000;
        step();
        taps = ALL_ONES;
        step();
        repeat (5) step();
        checkOutput("midrst_count", 32'(tsQ.size()), 32'd1);
        expectTs("midrst_event", 16'd13, 4'd12);

        // Same cycle position one full coarse period later yields the same coarse value.
        while (tbCnt < 65536 + 10) step();
        taps = 12'h000;
        step();
        taps = ALL_ONES;
        step();
        repeat (6) step();
        checkOutput("wrap_count", 32'(tsQ.size()), 32'd1);
        expectTs("wrap_event", 16'd13, 4'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
